// File: rtl/instr_word_encoder.sv
// instr_word_encoder: packs decoded RV32I fields into instruction words and writes them to
// consecutive instruction-memory addresses over a valid/ready handshake.
module instr_word_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, ENCODE, WRITE} state_t;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};
    state_t            state;
    logic [2:0]        fmt_q;
    logic [6:0]        opcode_q, funct7_q;
    logic [2:0]        funct3_q;
    logic [4:0]        rd_q, rs1_q, rs2_q;
    logic [31:0]       imm_q;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       word;
    logic              ok;
    logic              i_ok, b_ok, j_ok, u_ok;
    // An immediate fits N signed bits when every bit above N-1 matches the sign bit.
    always_comb begin
        i_ok = (&imm_q[31:11]) | ~(|imm_q[31:11]);
        b_ok = ((&imm_q[31:12]) | ~(|imm_q[31:12])) & ~imm_q[0];
        j_ok = ((&imm_q[31:20]) | ~(|imm_q[31:20])) & ~imm_q[0];
        u_ok = ~(|imm_q[11:0]);
        ok   = fmt_q == 3'd0 ? 1'b1 :
               fmt_q == 3'd1 || fmt_q == 3'd2 ? i_ok :
               fmt_q == 3'd3 ? b_ok :
               fmt_q == 3'd4 ? u_ok :
               fmt_q == 3'd5 ? j_ok : 1'b0;
        word = fmt_q == 3'd0 ? {funct7_q, rs2_q, rs1_q, funct3_q, rd_q, opcode_q} :
               fmt_q == 3'd1 ? {imm_q[11:0], rs1_q, funct3_q, rd_q, opcode_q} :
               fmt_q == 3'd2 ? {imm_q[11:5], rs2_q, rs1_q, funct3_q, imm_q[4:0], opcode_q} :
               fmt_q == 3'd3 ? {imm_q[12], imm_q[10:5], rs2_q, rs1_q, funct3_q, imm_q[4:1], imm_q[11], opcode_q} :
               fmt_q == 3'd4 ? {imm_q[31:12], rd_q, opcode_q} :
                               {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, opcode_q};
    end
    assign full     = count == CAP;
    assign in_ready = state == IDLE && !full && !clear;
    assign imem_we  = state == WRITE && !clear;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= BASE;
            imem_addr  <= BASE;
            imem_wdata <= '0;
            count      <= '0;
            err        <= 1'b0;
            fmt_q      <= '0;
            opcode_q   <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
        end else if (clear) begin
            state     <= IDLE;
            ptr       <= BASE;
            imem_addr <= BASE;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    fmt_q    <= fmt;
                    opcode_q <= opcode;
                    funct3_q <= funct3;
                    funct7_q <= funct7;
                    rd_q     <= rd;
                    rs1_q    <= rs1;
                    rs2_q    <= rs2;
                    imm_q    <= imm;
                    state    <= ENCODE;
                end
                ENCODE: begin
                    if (ok) begin
                        imem_wdata <= word;
                        imem_addr  <= ptr;
                        state      <= WRITE;
                    end else begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
                end
                WRITE: begin
                    ptr   <= ptr + 1'b1;
                    count <= count + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_word_encoder.sv
// tb_instr_word_encoder: directed vectors with a write scoreboard checked by a negedge monitor.
module tb_instr_word_encoder;
    localparam int AW = 2;
    logic clk = 0, rst_n = 0, clear = 0, in_valid = 0;
    logic in_ready, imem_we, full, err;
    logic [2:0] fmt = 0, funct3 = 0;
    logic [6:0] opcode = 0, funct7 = 0;
    logic [4:0] rd = 0, rs1 = 0, rs2 = 0;
    logic [31:0] imm = 0, imem_wdata;
    logic [AW-1:0] imem_addr;
    logic [AW:0] count;
    int checks = 0, errors = 0, cyc = 0, last_wr = 0, prev_wr = 0, exp_ptr = 0;
    logic [AW+31:0] q[$];

    instr_word_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .err(err));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            prev_wr = last_wr;
            last_wr = cyc;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", imem_addr, imem_wdata);
            end else begin
                logic [AW+31:0] e;
                e = q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr %h data %h expected addr %h data %h",
                             imem_addr, imem_wdata, e[AW+31:32], e[31:0]);
                end
            end
        end
    end

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im, input bit push,
                        input logic [31:0] exp_word);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got in_ready 0 expected 1");
        end
        fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1;
        if (push) begin
            q.push_back({AW'(exp_ptr), exp_word});
            exp_ptr++;
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1;
        @(posedge clk);
        #1 clear = 0;
        exp_ptr = 0;
    endtask

    initial begin
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_full", 32'(full), 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'sd5, 1, 32'hFFB00093);
        settle();
        chk("i_count", 32'(count), 1);
        send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd1, 32'd20, 1, 32'h00112A23);
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd0, 32'd28, 1, 32'h00008E63);
        settle();
        chk("sb_gap", 32'(last_wr - prev_wr), 3);
        chk("sb_count", 32'(count), 3);
        do_clear();
        chk("clr_count", 32'(count), 0);
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h002081B3);
        send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1, 32'h123452B7);
        send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1, 32'h001000EF);
        settle();
        chk("ruj_count", 32'(count), 3);
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd0, 32'd3, 0, 0);
        settle();
        chk("b_odd_err", 32'(err), 1);
        chk("b_odd_count", 32'(count), 3);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 0, 0);
        send(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 0, 0);
        @(negedge clk);
        chk("err_ready_encode", 32'(in_ready), 0);
        @(negedge clk);
        chk("err_ready_after", 32'(in_ready), 1);
        chk("err_count", 32'(count), 3);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd1, 1, 32'h00100113);
        settle();
        chk("full_count", 32'(count), 4);
        chk("full_flag", 32'(full), 1);
        chk("full_ready", 32'(in_ready), 0);
        chk("err_sticky", 32'(err), 1);
        in_valid = 1;
        repeat (6) @(negedge clk);
        in_valid = 0;
        chk("full_hold_count", 32'(count), 4);
        do_clear();
        chk("clr2_count", 32'(count), 0);
        chk("clr2_full", 32'(full), 0);
        chk("clr2_err", 32'(err), 0);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd1, 1, 32'h00100113);
        settle();
        chk("after_clr_count", 32'(count), 1);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd7, 0, 0);
        @(posedge clk);
        #1 clear = 1;
        #1 chk("clr_write_we", 32'(imem_we), 0);
        @(posedge clk);
        #1 clear = 0;
        exp_ptr = 0;
        chk("clr_write_count", 32'(count), 0);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd1, 1, 32'h00100113);
        send(3'd6, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 0, 0);
        settle();
        chk("fmt6_err", 32'(err), 1);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd9, 0, 0);
        rst_n = 0;
        #1;
        chk("rstm_we", 32'(imem_we), 0);
        chk("rstm_count", 32'(count), 0);
        chk("rstm_err", 32'(err), 0);
        chk("rstm_wdata", imem_wdata, 0);
        chk("rstm_addr", 32'(imem_addr), 0);
        exp_ptr = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1, 32'h001000EF);
        settle();
        chk("recover_count", 32'(count), 1);
        chk("queue_empty", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
